// File: rtl/ring_count_pkg.sv
// Shared constants and helpers for the one-hot ring counter.
// Optional self-correction is enabled by defining RING_COUNT_SELF_CORRECT_EN.
package ring_count_pkg;

    localparam int RING_COUNT_DEFAULT_WIDTH = 4;
    localparam int RING_COUNT_MAX_WIDTH     = 64;

    // MSB-one seed for a ring of the given width; callers truncate to their width.
    function automatic logic [RING_COUNT_MAX_WIDTH-1:0] ring_count_default_seed(input int width);
        logic [RING_COUNT_MAX_WIDTH-1:0] v;
        v            = '0;
        v[width-1]   = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ring_count_onehot_check.sv
// Combinational detector: o_onehot is high when exactly one bit of i_vec is set.
// Used by ring_count only when RING_COUNT_SELF_CORRECT_EN is defined.
module onehot_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_onehot
);

    assign o_onehot = ($countones(i_vec) == 1);

endmodule

// File: rtl/ring_count.sv
// One-hot ring counter: reset clears, ori loads SEED, otherwise rotate right by one.
// Define RING_COUNT_SELF_CORRECT_EN to reload SEED from any multi-hot state.
module ring_count
    import ring_count_pkg::*;
#(
    parameter int               WIDTH = RING_COUNT_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(ring_count_default_seed(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ori,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_rotated;
    logic [WIDTH-1:0] w_next;

    // Rotate right: the LSB wraps into the MSB; an all-zero ring stays idle.
    assign w_rotated = {r_count[0], r_count[WIDTH-1:1]};

`ifdef RING_COUNT_SELF_CORRECT_EN
    logic w_onehot;
    logic w_illegal;

    onehot_check #(
        .WIDTH (WIDTH)
    ) u_onehot_check (
        .i_vec    (r_count),
        .o_onehot (w_onehot)
    );

    assign w_illegal = (|r_count) && !w_onehot;
`endif

    // NOTE: the default is assigned first so every path drives w_next and no latch is inferred.
    always_comb begin
        w_next = w_rotated;
`ifdef RING_COUNT_SELF_CORRECT_EN
        if (w_illegal) begin
            w_next = SEED;
        end
`endif
        if (ori) begin
            w_next = SEED;
        end
    end

    // NOTE: state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_ring_count.sv
// Scoreboard bench for ring_count (WIDTH=4): the driver queues the expected value
// for each edge and a monitor compares it #1 after that edge.
module tb_ring_count;

    logic       clk;
    logic       rst;
    logic       ori;
    logic [3:0] count;

    logic [3:0] exp_q[$];
    int         total;
    int         bad;
    bit         stim_done;

    ring_count dut (
        .clk   (clk),
        .rst   (rst),
        .ori   (ori),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected value is consumed per rising edge.
    initial begin
        logic [3:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                total++;
                if (count !== exp_v) begin
                    bad++;
                    $display("FAIL count @%0t: got %b expected %b", $time, count, exp_v);
                end
            end
        end
    end

    task automatic step(input logic r, input logic o, input logic [3:0] exp_v);
        @(negedge clk);
        rst = r;
        ori = o;
        exp_q.push_back(exp_v);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rot_tbl [4];
        rot_tbl[0] = 4'b1000;
        rot_tbl[1] = 4'b0100;
        rot_tbl[2] = 4'b0010;
        rot_tbl[3] = 4'b0001;
        total = 0;
        bad   = 0;
        stim_done = 1'b0;
        rst = 1'b1;
        ori = 1'b0;

        // Reset, then idle with ori low.
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0000);

        // Seed, then three full revolutions.
        step(1'b0, 1'b1, 4'b1000);
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, rot_tbl[i % 4]);
        step(1'b0, 1'b0, 4'b0100);
        step(1'b0, 1'b0, 4'b0010);

        // Reload mid-rotation.
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b0, 4'b0100);

        // rst and ori together: reset wins.
        step(1'b1, 1'b1, 4'b0000);

        // ori held three cycles.
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b1, 4'b1000);
        step(1'b0, 1'b0, 4'b0100);
        step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0001);

        // Reset mid-run, then stays idle until ori.
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b1000);

        // Illegal multi-hot pattern forced into the register.
        @(negedge clk);
        force dut.r_count = 4'b0110;
        #1;
        release dut.r_count;
        rst = 1'b0;
        ori = 1'b0;
`ifdef RING_COUNT_SELF_CORRECT_EN
        exp_q.push_back(4'b1000);
        step(1'b0, 1'b0, 4'b0100);
`else
        exp_q.push_back(4'b0011);
        step(1'b0, 1'b0, 4'b1001);
`endif

        // Drain the scoreboard.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
